// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Round-robin arbiter for the common data bus. Picks at most one
//             functional-unit result per cycle and registers it onto the CDB
//             for the reservation stations, ROB and register file.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             flush               - pipeline flush, blocks grants this cycle
//             req_valid/tag/rd/data - packed per-requester results
//             req_ready           - one-hot grant (transfer on valid & ready)
//             cdb_valid/tag/rd/data/src - registered broadcast
//             perf_bcast_cnt, perf_conflict_cnt - saturating counters,
//                                   present only with CDB_ARB_PERF_EN defined
//  Options  : CDB_ARB_PERF_EN     - adds the two performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*5-1:0]      req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [4:0]                cdb_rd,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [IDX_W-1:0]          cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_bcast_cnt,
    output logic [31:0]               perf_conflict_cnt
`endif
);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic               w_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic [TAG_W-1:0]   w_win_tag;
    logic [4:0]         w_win_rd;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_xfer;
    logic [IDX_W-1:0]   w_ptr_next;

    // Two passes give the wrapped search order: first indices at or above
    // the pointer, then the ones below it. The first hit in that order wins.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_onehot   = '0;
        w_win_tag  = '0;
        w_win_rd   = '0;
        w_win_data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    ((p == 0) ? (IDX_W'(i) >= r_rr_ptr) : (IDX_W'(i) < r_rr_ptr))) begin
                    w_found     = 1'b1;
                    w_win_idx   = IDX_W'(i);
                    w_onehot[i] = 1'b1;
                    w_win_tag   = req_tag[i*TAG_W +: TAG_W];
                    w_win_rd    = req_rd[i*5 +: 5];
                    w_win_data  = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign req_ready = (rst || flush) ? '0 : w_onehot;
    assign w_xfer    = w_found && !flush;

    // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
    assign w_ptr_next = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : w_win_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_rd    <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (w_xfer) begin
            r_rr_ptr  <= w_ptr_next;
            cdb_valid <= 1'b1;
            cdb_tag   <= w_win_tag;
            cdb_rd    <= w_win_rd;
            cdb_data  <= w_win_data;
            cdb_src   <= w_win_idx;
        end else begin
            // Payload holds its last value; only the valid pulse drops.
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic w_multi_req;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bcast_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (cdb_valid && (perf_bcast_cnt != 32'hFFFF_FFFF)) begin
                perf_bcast_cnt <= perf_bcast_cnt + 32'd1;
            end
            if (w_multi_req && !flush && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter (NUM_REQ=4, TAG_W=6,
//             DATA_W=32). A behavioural model tracks the expected grant and
//             broadcast; directed vectors add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [TW-1:0]   tag_a  [N];
    logic [4:0]      rd_a   [N];
    logic [DW-1:0]   data_a [N];
    logic [N*TW-1:0] req_tag;
    logic [N*5-1:0]  req_rd;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [4:0]      cdb_rd;
    logic [DW-1:0]   cdb_data;
    logic [IW-1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]     perf_bcast_cnt;
    logic [31:0]     perf_conflict_cnt;
`endif

    always_comb begin
        req_tag  = '0;
        req_rd   = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = tag_a[i];
            req_rd[i*5 +: 5]     = rd_a[i];
            req_data[i*DW +: DW] = data_a[i];
        end
    end

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_rd    (cdb_rd),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_bcast_cnt    (perf_bcast_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr;
    bit            m_valid;
    logic [TW-1:0] m_tag;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_data;
    int            m_src;
    bit   [N-1:0]  m_pend;
    bit            model_on = 1'b0;
    longint        m_pb;
    longint        m_pc;

    // First valid requester in the order ptr, ptr+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        logic [N-1:0] t;
        t = v;
        for (int k = 0; k < N; k++) begin
            if (t[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_tag = '0; m_rd = '0; m_data = '0; m_src = 0;
            m_pend = '0; m_pb = 0; m_pc = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i]) chk("contract_valid_held", {63'd0, req_valid[i]}, 64'd1);
            end
            if (m_valid && m_pb < 64'hFFFF_FFFF) m_pb++;
            if ($countones(req_valid) >= 2 && !flush && m_pc < 64'hFFFF_FFFF) m_pc++;
            g = pick(req_valid, m_ptr);
            m_pend = req_valid;
            if (g >= 0 && !flush) begin
                m_valid = 1; m_tag = tag_a[g]; m_rd = rd_a[g]; m_data = data_a[g];
                m_src = g; m_ptr = (g + 1) % N;
                m_pend[g] = 1'b0;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e;
        int g;
        if (model_on) begin
            e = '0;
            g = pick(req_valid, m_ptr);
            if (!rst && !flush && g >= 0) e[g] = 1'b1;
            chk("model_req_ready", {60'd0, req_ready}, {60'd0, e});
            chk("model_cdb_valid", {63'd0, cdb_valid}, {63'd0, m_valid});
            chk("model_cdb_tag",   {58'd0, cdb_tag},   {58'd0, m_tag});
            chk("model_cdb_rd",    {59'd0, cdb_rd},    {59'd0, m_rd});
            chk("model_cdb_data",  {32'd0, cdb_data},  {32'd0, m_data});
            chk("model_cdb_src",   {62'd0, cdb_src},   64'(m_src));
`ifdef CDB_ARB_PERF_EN
            chk("model_perf_bcast",    {32'd0, perf_bcast_cnt},    64'(m_pb));
            chk("model_perf_conflict", {32'd0, perf_conflict_cnt}, 64'(m_pc));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) begin
            tag_a[i] = '0; rd_a[i] = '0; data_a[i] = '0;
        end
        tick; tick;
        rst = 1'b0;

        // Reset then idle
        for (int c = 0; c < 10; c++) begin
            mid;
            chk("idle_cdb_valid", {63'd0, cdb_valid}, 64'd0);
            chk("idle_req_ready", {60'd0, req_ready}, 64'd0);
            chk("idle_cdb_src",   {62'd0, cdb_src},   64'd0);
            tick;
        end

        // Single requester
        req_valid = 4'b0100; tag_a[2] = 6'h15; rd_a[2] = 5'd7; data_a[2] = 32'hDEADBEEF;
        mid;
        chk("single_ready", {60'd0, req_ready}, 64'h4);
        tick;
        req_valid = 4'b0000;
        mid;
        chk("single_valid", {63'd0, cdb_valid}, 64'd1);
        chk("single_tag",   {58'd0, cdb_tag},   64'h15);
        chk("single_rd",    {59'd0, cdb_rd},    64'd7);
        chk("single_data",  {32'd0, cdb_data},  64'hDEADBEEF);
        chk("single_src",   {62'd0, cdb_src},   64'd2);
        tick;
        mid;
        chk("single_valid_drop", {63'd0, cdb_valid}, 64'd0);
        tick;

        // Round-robin: all valid from reset, grants 0,1,2,3,0,1,2,3
        rst = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            tag_a[i] = 6'(i + 1); rd_a[i] = 5'(i + 10); data_a[i] = 32'hA000_0000 + 32'(i);
        end
        tick;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid;
            chk("rr_ready", {60'd0, req_ready}, 64'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_cdb_valid", {63'd0, cdb_valid}, 64'd1);
                chk("rr_cdb_src",   {62'd0, cdb_src},   64'((k - 1) % 4));
            end
            tick;
            if (k < 4) data_a[k % 4] = 32'hB000_0000 + 32'(k);
            else       req_valid[k % 4] = 1'b0;
        end
        mid;
        chk("rr_last_src",  {62'd0, cdb_src},  64'd3);
        chk("rr_last_data", {32'd0, cdb_data}, 64'hB000_0003);
        tick;

        // Wrap/skip: move pointer to 3, then 0 and 1 valid
        req_valid = 4'b0100;
        mid;
        chk("wrap_setup_ready", {60'd0, req_ready}, 64'h4);
        tick;
        req_valid = 4'b0011;
        mid;
        chk("wrap_grant0", {60'd0, req_ready}, 64'h1);
        tick;
        req_valid = 4'b0010;
        mid;
        chk("wrap_grant1", {60'd0, req_ready}, 64'h2);
        tick;
        req_valid = 4'b1001;
        mid;
        chk("wrap_ptr2_grant3", {60'd0, req_ready}, 64'h8);
        tick;
        req_valid = 4'b0001;
        mid;
        chk("wrap_then_grant0", {60'd0, req_ready}, 64'h1);
        tick;
        req_valid = 4'b0000;

        // Flush after a handshake; rd = 0 is still broadcast
        req_valid = 4'b0010; tag_a[1] = 6'h2A;
        mid;
        chk("flush_hs_ready", {60'd0, req_ready}, 64'h2);
        tick;
        req_valid = 4'b1000; tag_a[3] = 6'h3F; rd_a[3] = 5'd0; data_a[3] = 32'h1234_5678;
        flush = 1'b1;
        mid;
        chk("flush_pending_valid", {63'd0, cdb_valid}, 64'd1);
        chk("flush_pending_src",   {62'd0, cdb_src},   64'd1);
        chk("flush_pending_tag",   {58'd0, cdb_tag},   64'h2A);
        chk("flush_ready_zero",    {60'd0, req_ready}, 64'd0);
        tick;
        flush = 1'b0;
        mid;
        chk("flush_after_valid", {63'd0, cdb_valid}, 64'd0);
        chk("flush_after_ready", {60'd0, req_ready}, 64'h8);
        tick;
        req_valid = 4'b0000;
        mid;
        chk("rd0_valid", {63'd0, cdb_valid}, 64'd1);
        chk("rd0_src",   {62'd0, cdb_src},   64'd3);
        chk("rd0_rd",    {59'd0, cdb_rd},    64'd0);
        chk("rd0_data",  {32'd0, cdb_data},  64'h1234_5678);
        tick;

        // Reset mid-operation
        req_valid = 4'b0001;
        mid;
        chk("rstmid_ready", {60'd0, req_ready}, 64'h1);
        tick;
        req_valid = 4'b0000; rst = 1'b1;
        mid;
        chk("rstmid_registered_valid", {63'd0, cdb_valid}, 64'd1);
        chk("rstmid_ready_zero",       {60'd0, req_ready}, 64'd0);
        tick;
        rst = 1'b0;
        mid;
        chk("rstmid_cleared_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rstmid_cleared_data",  {32'd0, cdb_data},  64'd0);
        tick;

`ifdef CDB_ARB_PERF_EN
        rst = 1'b1;
        tick;
        rst = 1'b0; req_valid = 4'b1111;
        tick; req_valid = 4'b1110;
        tick; req_valid = 4'b1100;
        tick; req_valid = 4'b1000;
        tick; req_valid = 4'b0000;
        tick; tick;
        mid;
        chk("perf_conflict_lit", {32'd0, perf_conflict_cnt}, 64'd3);
        chk("perf_bcast_lit",    {32'd0, perf_bcast_cnt},    64'd4);
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
